sigmoid_share_sched: RTL

- Shares one `sigmoid` activation unit (combinational, DATA_LEN-bit fixed point) among NUM_REQ requesters, e.g. the PEs of one PU.
- A round-robin arbiter grants one request per cycle into a 2-stage registered pipeline around the unit.
- Results return on one shared response port, tagged with the requester index and backpressured by rsp_ready.
- Replaces per-PE sigmoid instances so the area is spent once per PU.

---
 rtl/sigmoid_share_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sigmoid_share_sched.sv
// sigmoid_share_sched: one sigmoid unit shared by NUM_REQ requesters.
//
// Purpose
//   A round-robin arbiter grants at most one request per cycle into a
//   two-stage pipeline:
//     - S1 holds {operand, id} and feeds the sigmoid unit combinationally.
//     - S2 holds {result, id} and drives the response port.
//   Responses come out in accept order and are backpressured by rsp_ready.
//
// Handshake semantics
//   - Request i transfers on a rising edge where req_valid[i] && req_ready[i].
//     The requester holds req_valid[i] and its req_data slice stable until
//     then.
//   - A response transfers on a rising edge where rsp_valid && rsp_ready.
//     rsp_data and rsp_id stay stable while rsp_valid is high and rsp_ready
//     is low.
//
// Ports
//   clk        : clock; all state updates on the rising edge.
//   rstn       : synchronous active-low reset.
//   req_valid  : per-requester request valid [NUM_REQ].
//   req_data   : packed operands; requester i uses [i*DATA_LEN +: DATA_LEN].
//   req_ready  : per-requester accept, one-hot or zero (combinational).
//   rsp_valid  : result valid.
//   rsp_data   : sigmoid(operand).
//   rsp_id     : index of the requester that issued the operand.
//   rsp_ready  : consumer accepts the result.
//   idle       : both stages empty and no request pending (combinational).
//
// ID_LEN must equal ceil(log2(NUM_REQ)).

// Hard sigmoid on signed fixed point with DATA_LEN/2 fractional bits:
// y = clamp(x/4 + 0.5, 0, 1). The sum is one bit wider than the operand so it
// cannot overflow before clamping.
module sigmoid #(
    parameter int DATA_LEN = 32
) (
    input  logic [DATA_LEN-1:0] x_i,
    output logic [DATA_LEN-1:0] y_o
);
    localparam int FRAC = DATA_LEN / 2;
    localparam logic [DATA_LEN:0] ONE_U  = {{DATA_LEN{1'b0}}, 1'b1} << FRAC;
    localparam logic [DATA_LEN:0] HALF_U = {{DATA_LEN{1'b0}}, 1'b1} << (FRAC - 1);

    logic signed [DATA_LEN:0] x_ext;
    logic signed [DATA_LEN:0] sum;

    always_comb begin
        x_ext = $signed({x_i[DATA_LEN-1], x_i});
        sum   = (x_ext >>> 2) + $signed(HALF_U);
        if (sum[DATA_LEN]) begin
            y_o = '0;
        end else if (sum > $signed(ONE_U)) begin
            y_o = ONE_U[DATA_LEN-1:0];
        end else begin
            y_o = sum[DATA_LEN-1:0];
        end
    end
endmodule

module sigmoid_share_sched #(
    parameter int DATA_LEN = 32,
    parameter int NUM_REQ  = 4,
    parameter int ID_LEN   = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [DATA_LEN-1:0]          rsp_data,
    output logic [ID_LEN-1:0]            rsp_id,
    input  logic                         rsp_ready,
    output logic                         idle
);
    logic [ID_LEN-1:0]   rr_ptr_q, rr_ptr_d;
    logic                s1_valid_q, s1_valid_d;
    logic [DATA_LEN-1:0] s1_data_q, s1_data_d;
    logic [ID_LEN-1:0]   s1_id_q, s1_id_d;
    logic                s2_valid_q, s2_valid_d;
    logic [DATA_LEN-1:0] s2_data_q, s2_data_d;
    logic [ID_LEN-1:0]   s2_id_q, s2_id_d;

    logic                s1_load, s2_load, accept;
    logic                win_found;
    logic [ID_LEN-1:0]   win_id;
    logic [ID_LEN-1:0]   cand;
    int                  cand_i;
    logic [DATA_LEN-1:0] sig_y;

    sigmoid #(.DATA_LEN(DATA_LEN)) u_sigmoid (
        .x_i (s1_data_q),
        .y_o (sig_y)
    );

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        cand_i    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_i = int'(rr_ptr_q) + k;
            if (cand_i >= NUM_REQ) begin
                cand_i = cand_i - NUM_REQ;
            end
            cand = ID_LEN'(cand_i);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // S2 empties when it is free or its result is being taken; S1 may load
    // whenever it is empty or moving into S2 in the same cycle, which gives
    // full-rate streaming. Grants are suppressed while reset is asserted.
    always_comb begin
        s2_load   = s1_valid_q && (!s2_valid_q || rsp_ready);
        s1_load   = !s1_valid_q || s2_load;
        accept    = rstn && win_found && s1_load;
        req_ready = accept ? (NUM_REQ'(1) << win_id) : '0;
    end

    // Next-state logic.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;

        if (accept) begin
            rr_ptr_d = (win_id == ID_LEN'(NUM_REQ - 1)) ? '0 : win_id + ID_LEN'(1);
        end

        if (s1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_data_d = req_data[int'(win_id)*DATA_LEN +: DATA_LEN];
                s1_id_d   = win_id;
            end
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = sig_y;
            s2_id_d    = s1_id_q;
        end else if (s2_valid_q && rsp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
        end
    end

    // Outputs.
    always_comb begin
        rsp_valid = s2_valid_q;
        rsp_data  = s2_data_q;
        rsp_id    = s2_id_q;
        idle      = !s1_valid_q && !s2_valid_q && (req_valid == '0);
    end
endmodule
